// File: rtl/reg_display_pkg.sv
// reg_display_pkg: shared constants and types for the register snapshot path.
package reg_display_pkg;
    localparam int NUM_REGS = 8;
    localparam int DATA_W = 32;
    typedef logic [$clog2(NUM_REGS)-1:0] row_idx_t;
    typedef enum logic {IDLE, OFFER} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational round-robin priority encoder; selects the first set
// mask bit at or after ptr_i, wrapping modulo N.
module rr_picker #(
    parameter int N = 8,
    parameter int W = $clog2(N)
) (
    input  logic [N-1:0] mask_i,
    input  logic [W-1:0] ptr_i,
    output logic         any_o,
    output logic [W-1:0] idx_o
);
    logic [W-1:0] cand;

    assign any_o = |mask_i;

    // Scan from the far end back towards ptr_i so the nearest hit is written last.
    always_comb begin
        idx_o = '0;
        cand = '0;
        for (int j = N - 1; j >= 0; j--) begin
            cand = W'((int'(ptr_i) + j) % N);
            if (mask_i[cand]) idx_o = cand;
        end
    end
endmodule

// File: rtl/reg_snapshot_scheduler.sv
// reg_snapshot_scheduler: shadows the CPU register file, tracks dirty registers and offers
// one consistent row snapshot at a time. REG_SNAPSHOT_REFRESH_EN adds a periodic full redraw.
module reg_snapshot_scheduler
    import reg_display_pkg::*;
#(
    parameter int NUM_REGS = reg_display_pkg::NUM_REGS,
    parameter int DATA_W = reg_display_pkg::DATA_W,
    parameter int REFRESH_CYCLES = 1000000
) (
    input  logic                               clock,
    input  logic                               resetn,
    input  logic [NUM_REGS-1:0][DATA_W-1:0]    register_file,
    input  logic                               freeze,
    output logic                               row_valid,
    input  logic                               row_ready,
    output logic [$clog2(NUM_REGS)-1:0]        row_idx,
    output logic [DATA_W-1:0]                  row_data,
    output logic [NUM_REGS-1:0]                dirty_mask
);
    localparam int IW = $clog2(NUM_REGS);

    state_t                          state_q;
    logic [IW-1:0]                   rr_ptr_q;
    logic [NUM_REGS-1:0][DATA_W-1:0] shadow_q;
    logic [NUM_REGS-1:0]             dirty_q, dirty_d;
    logic                            row_valid_q;
    logic [IW-1:0]                   row_idx_q;
    logic [DATA_W-1:0]               row_data_q;
    logic                            any, grant, refresh_hit;
    logic [IW-1:0]                   pick;

    rr_picker #(.N(NUM_REGS), .W(IW)) u_picker (
        .mask_i(dirty_q),
        .ptr_i (rr_ptr_q),
        .any_o (any),
        .idx_o (pick)
    );

`ifdef REG_SNAPSHOT_REFRESH_EN
    localparam int CW = $clog2(REFRESH_CYCLES);
    logic [CW-1:0] refresh_q;

    assign refresh_hit = refresh_q == CW'(REFRESH_CYCLES - 1);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) refresh_q <= '0;
        else refresh_q <= refresh_hit ? '0 : refresh_q + 1'b1;
    end
`else
    assign refresh_hit = 1'b0;
`endif

    assign grant = (state_q == IDLE) && !freeze && any;

    // The grant clear is applied last so it wins over a same-edge change.
    always_comb begin
        dirty_d = dirty_q | {NUM_REGS{refresh_hit}};
        for (int i = 0; i < NUM_REGS; i++)
            if (register_file[i] != shadow_q[i]) dirty_d[i] = 1'b1;
        if (grant) dirty_d[pick] = 1'b0;
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q     <= IDLE;
            rr_ptr_q    <= '0;
            shadow_q    <= '0;
            dirty_q     <= '1;
            row_valid_q <= 1'b0;
            row_idx_q   <= '0;
            row_data_q  <= '0;
        end else begin
            dirty_q <= dirty_d;
            if (grant) begin
                shadow_q[pick] <= register_file[pick];
                row_data_q     <= register_file[pick];
                row_idx_q      <= pick;
                row_valid_q    <= 1'b1;
                state_q        <= OFFER;
            end else if (state_q == OFFER && row_ready) begin
                rr_ptr_q    <= (row_idx_q == IW'(NUM_REGS - 1)) ? '0 : row_idx_q + 1'b1;
                row_valid_q <= 1'b0;
                state_q     <= IDLE;
            end
        end
    end

    assign row_valid  = row_valid_q;
    assign row_idx    = row_idx_q;
    assign row_data   = row_data_q;
    assign dirty_mask = dirty_q;
endmodule

// File: tb/tb_reg_snapshot_scheduler.sv
// tb_reg_snapshot_scheduler: scoreboard bench; expected rows are queued as registers change
// and checked as the drawer accepts them.
module tb_reg_snapshot_scheduler;
    import reg_display_pkg::*;

    localparam int N = 8;

    typedef struct packed {
        logic [2:0]  idx;
        logic [31:0] data;
    } row_t;

    logic              clock = 1'b0;
    logic              resetn = 1'b1;
    logic              freeze = 1'b0;
    logic              row_ready = 1'b0;
    logic              row_valid;
    logic [N-1:0][31:0] register_file = '0;
    row_idx_t          row_idx;
    logic [31:0]       row_data;
    logic [N-1:0]      dirty_mask;

    row_t       sb[$];
    int         errors = 0;
    int         checks = 0;
    int         xfers = 0;
    logic [2:0] ptr_m = 3'd0;

    always #5 clock = ~clock;

    reg_snapshot_scheduler #(.NUM_REGS(N), .DATA_W(32), .REFRESH_CYCLES(100)) dut (
        .clock        (clock),
        .resetn       (resetn),
        .register_file(register_file),
        .freeze       (freeze),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_idx      (row_idx),
        .row_data     (row_data),
        .dirty_mask   (dirty_mask)
    );

    // The transfer happens at the next rising edge; inputs stay put until posedge+1.
    always @(negedge clock) begin
        if (resetn && row_valid && row_ready) begin
            row_t e;
            checks++;
            xfers++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL row_unexpected: got idx=%0d data=%h, expected no row", row_idx, row_data);
            end else begin
                e = sb.pop_front();
                if (row_idx !== e.idx || row_data !== e.data) begin
                    errors++;
                    $display("FAIL row_xfer: got idx=%0d data=%h, expected idx=%0d data=%h",
                             row_idx, row_data, e.idx, e.data);
                end
            end
            ptr_m = row_idx + 3'd1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_row(input logic [2:0] i);
        sb.push_back(row_t'{idx: i, data: register_file[i]});
    endtask

    task automatic drain(input string name, input int budget);
        int n = 0;
        while (sb.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL %s_drain: %0d rows pending after %0d cycles, expected 0", name, sb.size(), budget);
            sb.delete();
        end
        repeat (4) tick();
    endtask

    task automatic wait_valid(input string name);
        int n = 0;
        while (!row_valid && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (!row_valid) begin
            errors++;
            $display("FAIL %s_valid: row_valid=%b after 20 cycles, expected 1", name, row_valid);
        end
    endtask

    task automatic test_reset();
        for (int i = 0; i < N; i++) register_file[i] = 32'h1000_0000 + i;
        row_ready = 1'b0;
        resetn = 1'b0;
        #1;
        checks++;
        if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b expected 0", row_valid); end
        checks++;
        if (row_idx !== 3'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", row_idx); end
        checks++;
        if (row_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %h expected 0", row_data); end
        checks++;
        if (dirty_mask !== 8'hFF) begin errors++; $display("FAIL reset_dirty: got %h expected ff", dirty_mask); end
        repeat (3) tick();
        checks++;
        if (row_valid !== 1'b0) begin errors++; $display("FAIL reset_hold_valid: got %b expected 0", row_valid); end
    endtask

    task automatic test_full_draw();
        row_ready = 1'b1;
        for (int i = 0; i < N; i++) expect_row(3'(i));
        tick();
        resetn = 1'b1;
        drain("full_draw", 40);
        checks++;
        if (dirty_mask !== 8'h00) begin errors++; $display("FAIL full_draw_dirty: got %h expected 00", dirty_mask); end
    endtask

    task automatic test_backpressure();
        logic [2:0]  cap_idx;
        logic [31:0] cap_data;
        int          x0;
        row_ready = 1'b0;
        tick();
        register_file[2] = 32'hA5A5_0002;
        expect_row(3'd2);
        wait_valid("backpressure");
        cap_idx = row_idx;
        cap_data = row_data;
        for (int c = 0; c < 10; c++) begin
            tick();
            checks++;
            if (row_valid !== 1'b1 || row_idx !== cap_idx || row_data !== cap_data) begin
                errors++;
                $display("FAIL backpressure_hold: got v=%b idx=%0d data=%h, expected v=1 idx=%0d data=%h",
                         row_valid, row_idx, row_data, cap_idx, cap_data);
            end
        end
        x0 = xfers;
        row_ready = 1'b1;
        drain("backpressure", 40);
        checks++;
        if (xfers - x0 != 1) begin errors++; $display("FAIL backpressure_count: got %0d transfers expected 1", xfers - x0); end
    endtask

    task automatic test_latency();
        row_ready = 1'b1;
        tick();
        register_file[3] = 32'hDEAD_BEEF;
        expect_row(3'd3);
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (row_valid !== 1'b0 || dirty_mask !== 8'h08) begin
            errors++;
            $display("FAIL latency_edge1: got v=%b dirty=%h, expected v=0 dirty=08", row_valid, dirty_mask);
        end
        @(posedge clock);
        @(negedge clock);
        checks++;
        if (row_valid !== 1'b1 || row_idx !== 3'd3 || row_data !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL latency_edge2: got v=%b idx=%0d data=%h, expected v=1 idx=3 data=deadbeef",
                     row_valid, row_idx, row_data);
        end
        drain("latency", 40);
    endtask

    task automatic test_order();
        row_ready = 1'b1;
        tick();
        register_file[1] = 32'h0000_1111;
        register_file[5] = 32'h0000_5555;
        expect_row(3'd5);
        expect_row(3'd1);
        drain("order_5_1", 40);
        register_file[6] = 32'h0000_6666;
        expect_row(3'd6);
        drain("order_6", 40);
        checks++;
        if (ptr_m !== 3'd7) begin errors++; $display("FAIL order_ptr: got %0d expected 7", ptr_m); end
        register_file[0] = 32'h0000_0A0A;
        register_file[7] = 32'h0000_7777;
        expect_row(3'd7);
        expect_row(3'd0);
        drain("order_7_0", 40);
    endtask

    task automatic test_freeze();
        logic seen = 1'b0;
        freeze = 1'b1;
        row_ready = 1'b1;
        tick();
        register_file[2] = 32'h2222_0002;
        register_file[6] = 32'h6666_0006;
        repeat (6) begin
            tick();
            if (row_valid) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL freeze_valid: got row_valid=1 expected 0"); end
        checks++;
        if (dirty_mask !== 8'h44) begin errors++; $display("FAIL freeze_dirty: got %h expected 44", dirty_mask); end
        expect_row(3'd2);
        expect_row(3'd6);
        freeze = 1'b0;
        drain("freeze", 40);
    endtask

    task automatic test_redirty();
        row_ready = 1'b0;
        tick();
        register_file[4] = 32'h0000_0001;
        expect_row(3'd4);
        wait_valid("redirty");
        register_file[4] = 32'h0000_0002;
        tick();
        tick();
        checks++;
        if (dirty_mask[4] !== 1'b1 || row_data !== 32'h1) begin
            errors++;
            $display("FAIL redirty_offer: got dirty4=%b data=%h, expected dirty4=1 data=00000001",
                     dirty_mask[4], row_data);
        end
        expect_row(3'd4);
        row_ready = 1'b1;
        drain("redirty", 40);
    endtask

    task automatic test_async_reset();
        row_ready = 1'b0;
        tick();
        register_file[1] = 32'h0BAD_0001;
        wait_valid("async_reset");
        #2;
        resetn = 1'b0;
        #1;
        checks++;
        if (row_valid !== 1'b0 || dirty_mask !== 8'hFF) begin
            errors++;
            $display("FAIL async_reset: got v=%b dirty=%h, expected v=0 dirty=ff", row_valid, dirty_mask);
        end
        row_ready = 1'b1;
        for (int i = 0; i < N; i++) expect_row(3'(i));
        tick();
        resetn = 1'b1;
        drain("async_reset", 40);
    endtask

`ifdef REG_SNAPSHOT_REFRESH_EN
    task automatic test_refresh();
        row_ready = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int j = 0; j < N; j++) expect_row(ptr_m + 3'(j));
            drain("refresh", 150);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_full_draw();
`ifdef REG_SNAPSHOT_REFRESH_EN
        test_refresh();
`else
        test_backpressure();
        test_latency();
        test_order();
        test_freeze();
        test_redirty();
        test_async_reset();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
